// File: rtl/spi_tx_arbiter.sv
// spi_tx_arbiter: round-robin sharing of one 12-bit SPI transmit master
// between NREQ requesters, with launch/busy timeouts and an inter-frame gap.
module spi_tx_arbiter #(
    parameter int NREQ    = 4,
    parameter int DW      = 12,
    parameter int TIMEOUT = 512,
    parameter int GAP     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DW-1:0]       req_data,
    output logic [NREQ-1:0]          req_ack,
    output logic                     spi_newdata,
    output logic [DW-1:0]            spi_din,
    input  logic                     spi_cs,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     done,
    output logic                     err
);

    localparam int IW = $clog2(NREQ);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_GAP
    } state_t;

    state_t          state;
    logic [15:0]     timer;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick;
    logic [IW-1:0]   idx;
    logic            pick_ok;
    logic [DW-1:0]   word;
    logic            cs_m;
    logic            cs_s;

    // Bring the master's chip select into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_m <= 1'b1;
            cs_s <= 1'b1;
        end else begin
            cs_m <= spi_cs;
            cs_s <= cs_m;
        end
    end

    // Round-robin search: closest set bit after the last grant wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(ptr) + k) % NREQ);
            if (req_valid[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end
    end

    assign word = req_data[int'(pick)*DW +: DW];

    // Sequencer: grant, launch, wait for frame end, then enforce the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            timer       <= '0;
            ptr         <= IW'(NREQ - 1);
            req_ack     <= '0;
            spi_newdata <= 1'b0;
            spi_din     <= '0;
            busy        <= 1'b0;
            grant_id    <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            req_ack <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            if (timer != 16'hFFFF) begin
                timer <= timer + 16'd1;
            end
            unique case (state)
                S_IDLE: begin
                    if (pick_ok && cs_s) begin
                        spi_din       <= word;
                        grant_id      <= pick;
                        ptr           <= pick;
                        req_ack[pick] <= 1'b1;
                        spi_newdata   <= 1'b1;
                        busy          <= 1'b1;
                        timer         <= '0;
                        state         <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    if (!cs_s) begin
                        spi_newdata <= 1'b0;
                        timer       <= '0;
                        state       <= S_BUSY;
                    end else if (timer == TO_LAST) begin
                        spi_newdata <= 1'b0;
                        err         <= 1'b1;
                        timer       <= '0;
                        state       <= S_GAP;
                    end
                end
                S_BUSY: begin
                    if (cs_s) begin
                        done  <= 1'b1;
                        timer <= '0;
                        state <= S_GAP;
                    end else if (timer == TO_LAST) begin
                        err   <= 1'b1;
                        timer <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (timer == GAP_LAST) begin
                        busy  <= 1'b0;
                        timer <= '0;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb_spi_tx_arbiter: vector table, corner-case sequences and random traffic
// against a round-robin reference model and a behavioural SPI master.
`timescale 1ns/1ps
module tb_spi_tx_arbiter;

    localparam int NREQ    = 4;
    localparam int DW      = 12;
    localparam int TIMEOUT = 512;
    localparam int GAP     = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req_valid = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ-1:0]    req_ack;
    logic               spi_newdata;
    logic [DW-1:0]      spi_din;
    logic               spi_cs = 1'b1;
    logic               busy;
    logic [1:0]         grant_id;
    logic               done;
    logic               err;

    int checks = 0;
    int failures = 0;

    spi_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ack(req_ack), .spi_newdata(spi_newdata), .spi_din(spi_din),
        .spi_cs(spi_cs), .busy(busy), .grant_id(grant_id), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Reference rule: first requester after the last grant, wrapping.
    function automatic int rr(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (((v >> ((last + k) % NREQ)) & 1) != 0) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Behavioural SPI master: 0 normal, 1 never starts, 2 never ends.
    int mmode = 0;
    int mst = 0;
    int mcnt = 0;
    logic [DW-1:0] cap_word = '0;
    bit cap_evt = 0;
    always @(posedge clk) begin
        cap_evt <= 0;
        if (rst) begin
            spi_cs <= 1'b1;
            mst <= 0;
        end else begin
            case (mst)
                0: if (spi_newdata && mmode != 1) begin
                    cap_word <= spi_din;
                    mcnt <= $urandom_range(1, 6);
                    mst <= 1;
                end
                1: if (mcnt == 0) begin
                    spi_cs <= 1'b0;
                    cap_evt <= 1;
                    mcnt <= $urandom_range(10, 40);
                    mst <= 2;
                end else mcnt <= mcnt - 1;
                2: if (mmode != 2) begin
                    if (mcnt == 0) begin
                        spi_cs <= 1'b1;
                        mcnt <= 3;
                        mst <= 3;
                    end else mcnt <= mcnt - 1;
                end
                default: if (mcnt == 0) mst <= 0; else mcnt <= mcnt - 1;
            endcase
        end
    end

    // Scoreboard: rotation, capture, pulse exclusivity and spacing.
    int cyc = 0;
    int last_end = -1000;
    int mptr = NREQ - 1;
    int mid = 0;
    int n_ack = 0;
    int n_done = 0;
    int n_err = 0;
    bit prev_ack = 0;
    logic [DW-1:0] exp_word = '0;
    logic [NREQ-1:0] last_valid = '0;
    logic [NREQ*DW-1:0] last_data = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        last_valid <= req_valid;
        last_data <= req_data;
    end

    always @(negedge clk) begin
        if (rst) begin
            mptr = NREQ - 1;
            last_end = -1000;
            prev_ack = 0;
        end else begin
            if (req_ack != 0) begin
                mid = -1;
                for (int i = 0; i < NREQ; i++)
                    if (((req_ack >> i) & 1) != 0) mid = i;
                chk($onehot(req_ack) && !prev_ack, "ack_pulse", int'(req_ack), 0);
                chk(mid == rr(mptr, last_valid), "rr_grant", mid, rr(mptr, last_valid));
                chk(int'(grant_id) == mid, "grant_id", int'(grant_id), mid);
                chk(spi_din == last_data[mid*DW +: DW], "din_capture",
                    int'(spi_din), int'(last_data[mid*DW +: DW]));
                chk(cyc - last_end >= GAP + 1, "ack_spacing", cyc - last_end, GAP + 1);
                exp_word = last_data[mid*DW +: DW];
                mptr = mid;
                n_ack++;
            end
            if (done || err) begin
                chk(!(done && err) && req_ack == 0, "done_err_excl",
                    int'({done, err, req_ack}), 0);
                chk(spi_din == exp_word, "din_hold", int'(spi_din), int'(exp_word));
                last_end = cyc;
                if (done) n_done++;
                if (err) n_err++;
            end
            if (cap_evt)
                chk(cap_word == exp_word, "frame_word", int'(cap_word), int'(exp_word));
            prev_ack = (req_ack != 0);
        end
    end

    task automatic wait_ack(output int id, input int budget);
        int n = 0;
        id = -1;
        while (req_ack == 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (req_ack == 0) chk(0, "ack_wait", n, budget);
        else for (int i = 0; i < NREQ; i++)
            if (((req_ack >> i) & 1) != 0) id = i;
    endtask

    task automatic wait_end(output bit e, input int budget);
        int n = 0;
        while (!(done || err) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(done || err)) chk(0, "end_wait", n, budget);
        e = err;
    endtask

    task automatic wait_idle(output int n, input int budget);
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk(0, "idle_wait", n, budget);
    endtask

    typedef struct {
        logic [NREQ-1:0]    valid;
        logic [NREQ*DW-1:0] data;
        int                 exp_id;
    } vec_t;

    vec_t tbl[8];
    int id, n, a0, d0, e0;
    bit e, ok;
    int rr_exp[5];

    initial begin
        tbl[0] = '{4'b0001, 48'h000_000_000_A5C, 0};
        tbl[1] = '{4'b1111, 48'h111_222_333_444, 1};
        tbl[2] = '{4'b1111, 48'h555_666_777_888, 2};
        tbl[3] = '{4'b0101, 48'h999_AAA_BBB_CCC, 0};
        tbl[4] = '{4'b1000, 48'hDDD_EEE_F0F_123, 3};
        tbl[5] = '{4'b0110, 48'h321_654_987_ABC, 1};
        tbl[6] = '{4'b1001, 48'hFED_CBA_987_654, 3};
        tbl[7] = '{4'b0100, 48'h0F0_0FF_F00_00F, 2};
        rr_exp = '{0, 1, 2, 3, 0};

        repeat (3) @(negedge clk);
        chk(req_ack == 0, "rst_ack", int'(req_ack), 0);
        chk(!spi_newdata && spi_din == 0, "rst_spi", int'({spi_newdata, spi_din}), 0);
        chk(!busy && grant_id == 0, "rst_busy_gid", int'({busy, grant_id}), 0);
        chk(!done && !err, "rst_done_err", int'({done, err}), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        foreach (tbl[i]) begin
            req_valid = tbl[i].valid;
            req_data = tbl[i].data;
            wait_ack(id, 50);
            chk(id == tbl[i].exp_id, "tbl_grant", id, tbl[i].exp_id);
            req_valid = '0;
            wait_end(e, 200);
            chk(!e, "tbl_done", int'(e), 0);
            wait_idle(n, 20);
            chk(n == GAP, "tbl_gap", n, GAP);
            @(negedge clk);
        end

        mmode = 1;
        req_valid = 4'b0010;
        req_data = 48'h000_000_5A5_000;
        wait_ack(id, 50);
        chk(id == 1, "lto_grant", id, 1);
        req_valid = '0;
        n = 0;
        ok = 1;
        while (!err && n < TIMEOUT + 50) begin
            if (!spi_newdata || done) ok = 0;
            @(negedge clk);
            n++;
        end
        chk(n == TIMEOUT, "lto_cycles", n, TIMEOUT);
        chk(ok, "lto_newdata_held", int'(ok), 1);
        chk(!spi_newdata && !done, "lto_drop", int'({spi_newdata, done}), 0);
        wait_idle(n, GAP + 20);
        chk(n == GAP, "lto_gap", n, GAP);
        mmode = 0;
        @(negedge clk);

        mmode = 2;
        req_valid = 4'b0010;
        wait_ack(id, 50);
        chk(id == 1, "bto_grant", id, 1);
        req_valid = '0;
        n = 0;
        while (spi_newdata && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(!spi_newdata, "bto_launch", int'(spi_newdata), 0);
        n = 0;
        ok = 1;
        while (!err && n < TIMEOUT + 50) begin
            if (spi_newdata || done) ok = 0;
            @(negedge clk);
            n++;
        end
        chk(n == TIMEOUT, "bto_cycles", n, TIMEOUT);
        chk(ok && !spi_newdata && !done, "bto_quiet", int'(ok), 1);
        mmode = 0;
        wait_idle(n, 200);
        repeat (60) @(negedge clk);

        req_valid = 4'b0100;
        req_data = 48'h000_FFF_000_000;
        wait_ack(id, 50);
        chk(id == 2, "mrst_grant", id, 2);
        req_valid = '0;
        n = 0;
        while (spi_newdata && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk(!busy && !spi_newdata && spi_din == 0, "mrst_async",
            int'({busy, spi_newdata, spi_din}), 0);
        chk(grant_id == 0 && req_ack == 0 && !done && !err, "mrst_async2",
            int'({grant_id, req_ack, done, err}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        a0 = n_ack;
        @(negedge clk);
        req_valid = 4'b1000;
        req_data = 48'h7E7_000_000_000;
        wait_ack(id, 50);
        chk(id == 3, "mrst_first", id, 3);
        req_valid = '0;
        wait_end(e, 200);
        wait_idle(n, 20);
        repeat (20) @(negedge clk);
        chk(n_ack == a0 + 1, "mrst_no_reack", n_ack - a0, 1);

        req_data = 48'h008_004_002_001;
        req_valid = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_ack(id, 200);
            chk(id == rr_exp[i], "rr_order", id, rr_exp[i]);
            chk(spi_din == DW'(1 << rr_exp[i]), "rr_word", int'(spi_din), 1 << rr_exp[i]);
            @(negedge clk);
        end
        req_valid = '0;
        wait_end(e, 200);
        wait_idle(n, 20);

        a0 = n_ack;
        d0 = n_done;
        e0 = n_err;
        repeat (300) begin
            @(negedge clk);
            req_valid = 4'($urandom_range(0, 15));
            req_data = 48'({$urandom(), $urandom()});
            repeat ($urandom_range(1, 40)) @(negedge clk);
        end
        req_valid = '0;
        repeat (2) @(negedge clk);
        wait_idle(n, 300);
        repeat (5) @(negedge clk);
        chk(n_done - d0 == n_ack - a0, "rand_done_count", n_done - d0, n_ack - a0);
        chk(n_err == e0, "rand_no_err", n_err - e0, 0);
        chk(n_ack - a0 > 20, "rand_activity", n_ack - a0, 21);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
